// File: rtl/counter64_reader.sv
// counter64_reader: read engine for a bank of counter64 instances.
// Walks counters 0..NUM_COUNTERS-1 after a start pulse. For each one it
// strobes the LSB sample, captures a coherent {MSB, LSB} pair and offers it
// on a valid/ready stream.
// Optional feature macro: COUNTER64_READER_CLEAR_EN (clear-on-read; pulses
// o_counter_rst[index] during CAPTURE). Without it o_counter_rst is 0.
//
// Stream handshake: a word transfers on a rising edge of i_clk where
// o_valid and i_ready are both high. While o_valid is high and i_ready is
// low, o_data/o_index/o_last hold and o_valid stays high until the transfer.
module counter64_reader #(
   parameter int NUM_COUNTERS = 4
) (
   input  logic                        i_clk,
   input  logic                        i_areset,
   input  logic                        i_start,
   output logic                        o_busy,
   output logic [NUM_COUNTERS-1:0]     o_lsb_sample,
   output logic [NUM_COUNTERS-1:0]     o_counter_rst,
   input  logic [32*NUM_COUNTERS-1:0]  i_msb,
   input  logic [32*NUM_COUNTERS-1:0]  i_lsb,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [7:0]                  o_index,
   output logic [63:0]                 o_data,
   output logic                        o_last,
   output logic [1:0]                  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_OUTPUT  = 2'd3
   } state_t;

   localparam logic [7:0] LAST_INDEX = 8'(NUM_COUNTERS - 1);

   state_t                  state;
   state_t                  state_next;
   logic [7:0]              index;
   logic [7:0]              index_next;
   logic [31:0]             msb_hold;
   logic [31:0]             lsb_hold;
   logic [31:0]             msb_sel;
   logic [31:0]             lsb_sel;
   logic [NUM_COUNTERS-1:0] sample_next;
   logic                    at_last;

   assign at_last     = (index == LAST_INDEX);
   assign o_dbg_state = state;
   // Word registers feed the stream directly; they only change in
   // SAMPLE/CAPTURE, so they are stable throughout OUTPUT.
   assign o_data      = {msb_hold, lsb_hold};
   assign o_index     = index;

   // Select the MSB/LSB lanes of the counter currently being read.
   always_comb begin
      msb_sel = '0;
      lsb_sel = '0;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         if (index == 8'(k)) begin
            msb_sel = i_msb[32*k +: 32];
            lsb_sel = i_lsb[32*k +: 32];
         end
      end
   end

   // Next-state and next-index logic of the scan FSM.
   always_comb begin
      state_next = state;
      index_next = index;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               index_next = '0;
               state_next = ST_SAMPLE;
            end
         end
         ST_SAMPLE:  state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_OUTPUT;
         ST_OUTPUT: begin
            if (i_ready) begin
               if (at_last) begin
                  state_next = ST_IDLE;
               end else begin
                  index_next = index + 8'd1;
                  state_next = ST_SAMPLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // One-hot sample strobe for the counter about to enter SAMPLE.
   always_comb begin
      sample_next = '0;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         sample_next[k] = (state_next == ST_SAMPLE) && (index_next == 8'(k));
      end
   end

   // State and index registers.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         state <= ST_IDLE;
         index <= '0;
      end else begin
         state <= state_next;
         index <= index_next;
      end
   end

   // MSB is taken on the same edge the counter latches its LSB, so the
   // pair read back in CAPTURE describes one instant of the counter.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         msb_hold <= '0;
         lsb_hold <= '0;
      end else begin
         if (state == ST_SAMPLE) begin
            msb_hold <= msb_sel;
         end
         if (state == ST_CAPTURE) begin
            lsb_hold <= lsb_sel;
         end
      end
   end

   // Registered stream and status outputs, decoded from the next state.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         o_busy       <= 1'b0;
         o_valid      <= 1'b0;
         o_last       <= 1'b0;
         o_lsb_sample <= '0;
      end else begin
         o_busy       <= (state_next != ST_IDLE);
         o_valid      <= (state_next == ST_OUTPUT);
         o_last       <= (state_next == ST_OUTPUT) && (index_next == LAST_INDEX);
         o_lsb_sample <= sample_next;
      end
   end

`ifdef COUNTER64_READER_CLEAR_EN
   logic [NUM_COUNTERS-1:0] clear_next;

   // One-hot clear strobe for the counter about to enter CAPTURE; its value
   // has already been sampled, so clearing now only loses late increments.
   always_comb begin
      clear_next = '0;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         clear_next[k] = (state_next == ST_CAPTURE) && (index_next == 8'(k));
      end
   end

   // Registered clear strobe.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         o_counter_rst <= '0;
      end else begin
         o_counter_rst <= clear_next;
      end
   end
`else
   assign o_counter_rst = '0;
`endif

endmodule

// File: tb/tb_counter64_reader.sv
// Bench for counter64_reader: a behavioural counter bank, a scoreboard fed
// with each counter's value at its sample instant, and a stream monitor.
module tb_counter64_reader;

   localparam int N = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start = 1'b0;
   logic              ready = 1'b1;
   logic              busy;
   logic              valid;
   logic              last;
   logic [N-1:0]      lsb_sample;
   logic [N-1:0]      counter_rst;
   logic [32*N-1:0]   msb_bus;
   logic [32*N-1:0]   lsb_bus;
   logic [7:0]        index;
   logic [63:0]       data;
   logic [1:0]        dbg_state;

   counter64_reader #(.NUM_COUNTERS(N)) dut (
      .i_clk         (clk),
      .i_areset      (rst),
      .i_start       (start),
      .o_busy        (busy),
      .o_lsb_sample  (lsb_sample),
      .o_counter_rst (counter_rst),
      .i_msb         (msb_bus),
      .i_lsb         (lsb_bus),
      .o_valid       (valid),
      .i_ready       (ready),
      .o_index       (index),
      .o_data        (data),
      .o_last        (last),
      .o_dbg_state   (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- counter bank model ----------------
   logic [63:0] cnt      [N];
   logic [31:0] lsb_lat  [N];
   logic [63:0] load_val [N];
   logic [N-1:0] inc_en = '0;
   logic        load = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (load) begin
            cnt[k]     <= load_val[k];
            lsb_lat[k] <= '0;
         end else begin
            if (lsb_sample[k]) lsb_lat[k] <= cnt[k][31:0];
            if (counter_rst[k]) cnt[k] <= '0;
            else if (inc_en[k]) cnt[k] <= cnt[k] + 64'd1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         msb_bus[32*k +: 32] = cnt[k][63:32];
         lsb_bus[32*k +: 32] = lsb_lat[k];
      end
   end

   // ---------------- ready driver ----------------
   int ready_mode = 0;
   int stall_cnt  = 0;

   always @(posedge clk) begin
      #1;
      if (ready_mode != 2) stall_cnt = 0;
      case (ready_mode)
         0: ready = 1'b1;
         1: ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (valid && index == 8'd1 && stall_cnt < 5) begin
               ready = 1'b0;
               stall_cnt++;
            end else begin
               ready = 1'b1;
            end
         end
         3: ready = !(valid && index == 8'd2);
         default: ready = 1'b1;
      endcase
   end

   // ---------------- scoreboard / monitor ----------------
   logic [72:0]  exp_q[$];
   int           accepted   = 0;   // words handed over in the current scan
   int           words_seen = 0;
   logic         held       = 1'b0;
   logic [72:0]  hold_val;
   logic [N-1:0] prev_sample = '0;
   logic [63:0]  word0_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         accepted    = 0;
         held        = 1'b0;
         prev_sample = '0;
      end else begin
         // sample strobe: must target the next unread counter only
         if (lsb_sample != '0) begin
            logic [N-1:0] want_oh;
            int           k;
            k = (accepted < N) ? accepted : 0;
            want_oh = '0;
            want_oh[k] = 1'b1;
            total++;
            if (lsb_sample != want_oh) begin
               bad++;
               $display("FAIL strobe: got %b want %b", lsb_sample, want_oh);
            end
            exp_q.push_back({(k == N - 1), 8'(k), cnt[k]});
         end
`ifdef COUNTER64_READER_CLEAR_EN
         if (prev_sample != '0 || counter_rst != '0) begin
            total++;
            if (counter_rst != prev_sample) begin
               bad++;
               $display("FAIL clear_strobe: got %b want %b", counter_rst, prev_sample);
            end
         end
`else
         if (prev_sample != '0) begin
            total++;
            if (counter_rst != '0) begin
               bad++;
               $display("FAIL clear_strobe: got %b want 0", counter_rst);
            end
         end
`endif
         prev_sample = lsb_sample;

         // stream side
         if (valid) begin
            if (held) begin
               total++;
               if ({last, index, data} != hold_val) begin
                  bad++;
                  $display("FAIL stall_hold: got %h want %h", {last, index, data}, hold_val);
               end
            end
            if (ready) begin
               logic [72:0] e;
               held = 1'b0;
               words_seen++;
               if (index == 8'd0) word0_data = data;
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL word: got idx=%0d data=%h want none", index, data);
               end else begin
                  e = exp_q.pop_front();
                  if ({last, index, data} != e) begin
                     bad++;
                     $display("FAIL word: got last=%0b idx=%0d data=%h want last=%0b idx=%0d data=%h",
                              last, index, data, e[72], e[71:64], e[63:0]);
                  end
                  if (e[72]) accepted = 0;
                  else accepted++;
               end
            end else begin
               held     = 1'b1;
               hold_val = {last, index, data};
            end
         end else if (held) begin
            total++;
            bad++;
            held = 1'b0;
            $display("FAIL valid_drop: got valid=0 want 1");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {busy, valid, last, index, 4'(lsb_sample), 4'(counter_rst)}, '0);
      chk({name, "_data"}, data, '0);
   endtask

   task automatic load_counters();
      @(posedge clk);
      #1 load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic run_scan(input bit mid_start, input bit chk_timing,
                           output int busy_cycles, output int words);
      int w0;
      bit done;
      w0 = words_seen;
      done = 1'b0;
      busy_cycles = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (chk_timing && c == 0) chk("t1_busy_sample", {busy, 4'(lsb_sample)}, {1'b1, 4'b0001});
         if (chk_timing && c == 1) chk("t2_no_valid", {busy, valid}, 2'b10);
         if (chk_timing && c == 2) chk("t3_valid", valid, 1'b1);
         if (mid_start) start = (c == 4);
         if (!busy) begin
            done = 1'b1;
            break;
         end
         busy_cycles++;
      end
      start = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL scan_timeout: got busy after 400 cycles want idle");
      end
      words = words_seen - w0;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int bc;
      int w;
      bit hit;

      for (int k = 0; k < N; k++) load_val[k] = 64'h0000_0001_FFFF_FFF0 + 64'(k);
      load = 1'b1;

      // reset, with start asserted while in reset
      repeat (2) @(negedge clk);
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_all_zero("reset_outputs");
      end
      start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      load = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_all_zero("idle_outputs");
      end

      // full scan, ready high: latency and 12-cycle duration
      ready_mode = 0;
      load_counters();
      run_scan(1'b0, 1'b1, bc, w);
      chk("scan_busy_cycles", 64'(bc), 64'd12);
      chk("scan_words", 64'(w), 64'(N));

      // backpressure on word 1 for 5 cycles
      ready_mode = 2;
      run_scan(1'b0, 1'b0, bc, w);
      chk("stall_busy_cycles", 64'(bc), 64'd17);
      chk("stall_words", 64'(w), 64'(N));

      // start pulsed mid-scan is ignored and not queued
      ready_mode = 0;
      run_scan(1'b1, 1'b0, bc, w);
      chk("midstart_words", 64'(w), 64'(N));
      chk("midstart_busy_cycles", 64'(bc), 64'd12);
      repeat (3) @(negedge clk);
      chk("midstart_not_queued", busy, 1'b0);

      // reset while word 2 waits in OUTPUT
      ready_mode = 3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (valid && index == 8'd2) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reach_word2", hit, 1'b1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midscan_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      ready_mode = 0;
      repeat (2) @(negedge clk);
      chk_all_zero("post_reset_idle");
      run_scan(1'b0, 1'b0, bc, w);
      chk("restart_words", 64'(w), 64'(N));

      // randomized values, increments and backpressure
      ready_mode = 1;
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < N; k++) load_val[k] = {$urandom(), $urandom()};
         inc_en = N'($urandom_range(0, (1 << N) - 1));
         load_counters();
         run_scan(1'b0, 1'b0, bc, w);
         chk("rand_words", 64'(w), 64'(N));
      end

      // coherence across the LSB rollover of counter 2
      ready_mode = 0;
      inc_en = 4'b0100;
      for (int d = 0; d < 12; d++) begin
         for (int k = 0; k < N; k++) load_val[k] = 64'(k) << 40;
         load_val[2] = 64'h0000_0005_FFFF_FFFF - 64'(d);
         load_counters();
         run_scan(1'b0, 1'b0, bc, w);
         chk("rollover_words", 64'(w), 64'(N));
      end
      inc_en = '0;

`ifdef COUNTER64_READER_CLEAR_EN
      // clear-on-read: second scan reads zero
      for (int k = 0; k < N; k++) load_val[k] = 64'h1000 + 64'(k);
      load_val[0] = 64'd100;
      load_counters();
      run_scan(1'b0, 1'b0, bc, w);
      chk("clear_first_read", word0_data, 64'd100);
      run_scan(1'b0, 1'b0, bc, w);
      chk("clear_second_read", word0_data, 64'd0);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
